bram_matrix_loader: RTL and testbench
=====================================

# bram_matrix_loader

Host-side writer that fills a matrix buffer BRAM with the lane-interleaved layout the systolic memory controller later reads back. It accepts a 64-bit valid/ready word stream, scatters each word to its lane/line address, and writes it through a single BRAM write port. When the full matrix is written it issues a one-cycle `calc_init` request so the controller can start. It sits between the host DMA stream and the HASH/SP BRAM write port.

## Interface
Parameters:
- `LANES`, 4: words per line group; lane index is the inner stream order.
- `LINE_STRIDE`, 64: byte distance between consecutive lines of one lane.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a load; sampled only in IDLE.
- `base_addr` input 32: byte base address; latched on `start`.
- `matrix_size` input 11: lines per lane; latched on `start`.
- `bram_busy` input 1: high while the controller owns the BRAM; stalls loading.
- `s_valid` input 1: stream word valid.
- `s_ready` output 1: loader accepts a word this cycle.
- `s_data` input 64: stream word.
- `s_last` input 1: sender's final-word marker.
- `wr_addr` output 32: BRAM byte address (registered).
- `wr_data` output 64: BRAM write data (registered).
- `wr_en` output 1: BRAM write enable (registered).
- `calc_init` output 1: one-cycle pulse when the load completes.
- `busy` output 1: high in LOAD and DONE.
- `err_len` output 1: one-cycle pulse on a length mismatch.
- `words_written` output 16: accepted beats in the current/last load.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: on `start`, latch `base_addr`, `matrix_size` and `lane_stride = matrix_size*LINE_STRIDE`. The multiply is 32-bit; address sums wrap mod 2^32.
  - Clear counters and `words_written`, then go to LOAD.
  - If `matrix_size==0`, go to DONE instead, with no writes.
- LOAD:
  - `s_ready = !bram_busy`. A beat is accepted when `s_valid && s_ready`.
  - Counter `lane` runs 0..LANES-1; counter `line` runs 0..matrix_size-1.
  - The target address of each beat is `base + line*LINE_STRIDE + lane*lane_stride`.
  - Compute the address incrementally; no per-beat multiplier is allowed:
    - `line_base` advances by LINE_STRIDE when `lane` wraps.
    - `lane_off` advances by `lane_stride` on every beat and resets to 0 when `lane` wraps.
  - The beat with `lane==LANES-1` and `line==matrix_size-1` is final: go to DONE.
  - `s_last` on a non-final beat: pulse `err_len`, write that beat, go to DONE (truncated load).
  - Final beat without `s_last`: pulse `err_len`, complete normally.
- DONE: pulse `calc_init` for one cycle, go to IDLE.
- `start` outside IDLE is ignored.
- `words_written` increments per accepted beat and holds its value in IDLE.

## Timing
- Reset: state IDLE; all outputs 0 (`s_ready`, `wr_en`, `calc_init`, `busy`, `err_len`, `wr_addr`, `wr_data`, `words_written`). Reset mid-load aborts with no further writes and no `calc_init`.
- `s_ready` is combinational from state and `bram_busy`. It is 0 in IDLE and DONE.
- Write latency is 1 cycle: a beat accepted at cycle N drives `wr_en=1` with its `wr_addr`/`wr_data` at N+1. `wr_en` is 0 in all other cycles.
- `err_len` is asserted in the cycle after the offending accept, aligned with that beat's `wr_en`.
- The final write and the DONE state fall in the same cycle; `calc_init` is high that cycle and is the only pulse.
- With `matrix_size==0`: `start` at N gives `calc_init` at N+2.
- Throughput is one word per cycle when `bram_busy=0`. The counters hold while stalled.

## Structure
- Shared package: state enum `loader_state_t`, the LANES/LINE_STRIDE defaults, and the 64-bit word typedef, shared with the memory controller.
- Sub-module `lane_line_counter`: the nested lane/line counters with incremental `line_base`/`lane_off` generation, and the final/wrap flags.

## Test plan
- **Nominal:** `base_addr=0x1000`, `matrix_size=2`, 8 back-to-back beats, `s_last` on beat 8.
  - Addresses in order: 0x1000, 0x1080, 0x1100, 0x1180, 0x1040, 0x10C0, 0x1140, 0x11C0.
  - `calc_init` pulses once at the final write; `words_written=8`; no `err_len`.
- **Backpressure:** as nominal, with `bram_busy=1` for 3 cycles mid-stream and random `s_valid` gaps.
  - Same address sequence; no dropped or duplicated writes; `s_ready=0` exactly while busy.
- **Zero size:** `matrix_size=0`.
  - No `wr_en`; `calc_init` exactly 2 cycles after `start`.
- **Early `s_last`:** `matrix_size=2`, `s_last` on beat 5.
  - 5 writes; `err_len` pulses with the 5th write; `calc_init` pulses; `words_written=5`.
- **Missing `s_last` / ignored `start`:** no `s_last` on the final beat, and `start` re-asserted mid-load.
  - `err_len` pulses with the final write; the latched `base_addr` and `matrix_size` are unchanged.
- **Reset mid-load:** assert `rst_n=0` after 3 writes.
  - All outputs go to 0 immediately; no `calc_init`; a new `start` reloads from the new base.

Source files
------------

// File: rtl/bram_matrix_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_matrix_loader_pkg
// Description : Types and defaults shared by the matrix loader and the
//               systolic memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_matrix_loader_pkg;

    localparam int unsigned C_LANES       = 4;
    localparam int unsigned C_LINE_STRIDE = 64;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

endpackage : bram_matrix_loader_pkg
`default_nettype wire

// File: rtl/bram_matrix_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_matrix_loader_if
// Description : Host word stream plus BRAM write port of the matrix loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_matrix_loader_if;
    import bram_matrix_loader_pkg::*;

    logic        s_valid;
    logic        s_ready;
    word_t       s_data;
    logic        s_last;
    logic [31:0] wr_addr;
    word_t       wr_data;
    logic        wr_en;

    // Loader side: consumes the stream, drives the BRAM write port.
    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_addr, wr_data, wr_en
    );

    // Host side: produces the stream, observes the BRAM write port.
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_addr, wr_data, wr_en
    );

endinterface : bram_matrix_loader_if
`default_nettype wire

// File: rtl/bram_matrix_loader_lane_line_counter.sv
`default_nettype none
// ============================================================================
// Module      : lane_line_counter
// Description : Nested lane/line counters with incremental lane-interleaved
//               address generation (no per-beat multiplier).
// Revision    : 1.0 - initial release
// ============================================================================
module lane_line_counter
    import bram_matrix_loader_pkg::*;
#(
    parameter int unsigned LANES       = C_LANES,
    parameter int unsigned LINE_STRIDE = C_LINE_STRIDE
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clear,
    input  wire logic        advance,
    input  wire logic [31:0] base_addr,
    input  wire logic [31:0] lane_stride,
    input  wire logic [10:0] last_line,
    output logic      [31:0] addr,
    output logic             lane_wrap,
    output logic             is_final
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane_q,      lane_d;
    logic [10:0]       line_q,      line_d;
    logic [31:0]       line_base_q, line_base_d;
    logic [31:0]       lane_off_q,  lane_off_d;

    // line_base carries the latched base so the address is a single add.
    assign addr      = line_base_q + lane_off_q;
    assign lane_wrap = (lane_q == LANE_W'(LANES - 1));
    assign is_final  = lane_wrap && (line_q == last_line);

    always_comb begin
        lane_d      = lane_q;
        line_d      = line_q;
        line_base_d = line_base_q;
        lane_off_d  = lane_off_q;
        if (clear) begin
            lane_d      = '0;
            line_d      = '0;
            line_base_d = base_addr;
            lane_off_d  = '0;
        end else if (advance) begin
            if (lane_wrap) begin
                lane_d      = '0;
                line_d      = line_q + 11'd1;
                line_base_d = line_base_q + 32'(LINE_STRIDE);
                lane_off_d  = '0;
            end else begin
                lane_d      = lane_q + LANE_W'(1);
                lane_off_d  = lane_off_q + lane_stride;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q      <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            lane_off_q  <= '0;
        end else begin
            lane_q      <= lane_d;
            line_q      <= line_d;
            line_base_q <= line_base_d;
            lane_off_q  <= lane_off_d;
        end
    end

endmodule : lane_line_counter
`default_nettype wire

// File: rtl/bram_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram_matrix_loader
// Description : Scatters a 64-bit host word stream into the lane-interleaved
//               matrix BRAM layout and requests calc_init when complete.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_matrix_loader
    import bram_matrix_loader_pkg::*;
#(
    parameter int unsigned LANES       = C_LANES,
    parameter int unsigned LINE_STRIDE = C_LINE_STRIDE
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            start,
    input  wire logic [31:0]     base_addr,
    input  wire logic [10:0]     matrix_size,
    input  wire logic            bram_busy,
    bram_matrix_loader_if.slave  bus,
    output logic                 calc_init,
    output logic                 busy,
    output logic                 err_len,
    output logic      [15:0]     words_written
);

    loader_state_t state_q,       state_d;
    logic [10:0]   size_q,        size_d;
    logic [31:0]   lane_stride_q, lane_stride_d;
    logic [31:0]   wr_addr_q,     wr_addr_d;
    word_t         wr_data_q,     wr_data_d;
    logic          wr_en_q,       wr_en_d;
    logic          calc_init_q,   calc_init_d;
    logic          err_len_q,     err_len_d;
    logic [15:0]   words_q,       words_d;

    logic          cnt_clear;
    logic          accept;
    logic [31:0]   beat_addr;
    logic          lane_wrap;
    logic          is_final;

    assign bus.s_ready = (state_q == ST_LOAD) && !bram_busy;
    assign accept      = bus.s_ready && bus.s_valid;
    assign cnt_clear   = (state_q == ST_IDLE) && start;

    lane_line_counter #(
        .LANES       (LANES),
        .LINE_STRIDE (LINE_STRIDE)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cnt_clear),
        .advance     (accept),
        .base_addr   (base_addr),
        .lane_stride (lane_stride_d),
        .last_line   (size_q - 11'd1),
        .addr        (beat_addr),
        .lane_wrap   (lane_wrap),
        .is_final    (is_final)
    );

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        lane_stride_d = lane_stride_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        calc_init_d   = 1'b0;
        err_len_d     = 1'b0;
        words_d       = words_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d        = matrix_size;
                    lane_stride_d = 32'(matrix_size) * 32'(LINE_STRIDE);
                    words_d       = '0;
                    state_d       = (matrix_size == 11'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = beat_addr;
                    wr_data_d = bus.s_data;
                    words_d   = words_q + 16'd1;
                    if (is_final || bus.s_last) begin
                        // Truncated (s_last early) or unterminated final beat both flag err_len.
                        err_len_d   = is_final ? !bus.s_last : 1'b1;
                        calc_init_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A load entering DONE has already pulsed; an empty load pulses here.
                if (calc_init_q) begin
                    state_d = ST_IDLE;
                end else begin
                    calc_init_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            size_q        <= '0;
            lane_stride_q <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            calc_init_q   <= 1'b0;
            err_len_q     <= 1'b0;
            words_q       <= '0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            lane_stride_q <= lane_stride_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            calc_init_q   <= calc_init_d;
            err_len_q     <= err_len_d;
            words_q       <= words_d;
        end
    end

    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_en      = wr_en_q;
    assign calc_init      = calc_init_q;
    assign err_len        = err_len_q;
    assign words_written  = words_q;
    assign busy           = (state_q != ST_IDLE);

endmodule : bram_matrix_loader
`default_nettype wire

// File: tb/tb_bram_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_matrix_loader
// Description : Directed scoreboard bench for bram_matrix_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_matrix_loader;
    import bram_matrix_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bram_busy = 1'b0;
    logic [31:0] base_addr = '0;
    logic [10:0] matrix_size = '0;
    logic        calc_init;
    logic        busy;
    logic        err_len;
    logic [15:0] words_written;

    bram_matrix_loader_if bus ();

    bram_matrix_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .matrix_size   (matrix_size),
        .bram_busy     (bram_busy),
        .bus           (bus),
        .calc_init     (calc_init),
        .busy          (busy),
        .err_len       (err_len),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic        err;
        logic        calc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int calc_cnt = 0, err_cnt = 0, wr_cnt = 0;
    logic [31:0] m_base;
    int m_size, m_lane, m_line;
    int c0, e0, w0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every write must match the oldest expected beat.
    always @(negedge clk) begin
        if (calc_init === 1'b1) calc_cnt++;
        if (err_len === 1'b1) err_cnt++;
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("write_without_beat", 64'(bus.wr_en), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr",   64'(bus.wr_addr), 64'(mon_e.addr));
                chk("wr_data",   bus.wr_data,      mon_e.data);
                chk("err_align", 64'(err_len),     64'(mon_e.err));
                chk("calc_align",64'(calc_init),   64'(mon_e.calc));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input int sz);
        start       = 1'b1;
        base_addr   = b;
        matrix_size = 11'(sz);
        tick();
        start  = 1'b0;
        m_base = b;
        m_size = sz;
        m_lane = 0;
        m_line = 0;
    endtask

    task automatic send(input logic [63:0] d, input logic last, input int gap);
        int   t;
        logic fin;
        exp_t e;
        bus.s_valid = 1'b0;
        repeat (gap) tick();
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        t = 0;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
        fin    = (m_lane == C_LANES - 1) && (m_line == m_size - 1);
        e.addr = m_base + 32'(m_line * 64) + 32'(m_lane * m_size * 64);
        e.data = d;
        e.err  = fin ? !last : last;
        e.calc = fin || last;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (m_lane == C_LANES - 1) begin
            m_lane = 0;
            m_line++;
        end else begin
            m_lane++;
        end
    endtask

    task automatic stall(input int n);
        bus.s_valid = 1'b1;
        bus.s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        bram_busy   = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("ready_while_busy", 64'(bus.s_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bram_busy   = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic mark;
        c0 = calc_cnt;
        e0 = err_cnt;
        w0 = wr_cnt;
    endtask

    task automatic finish_load(input string tag, input int n_wr, input int n_err, input int n_words);
        repeat (4) tick();
        chk({tag, "_calc"},  64'(calc_cnt - c0), 64'd1);
        chk({tag, "_err"},   64'(err_cnt - e0),  64'(n_err));
        chk({tag, "_writes"},64'(wr_cnt - w0),   64'(n_wr));
        chk({tag, "_words"}, 64'(words_written), 64'(n_words));
        chk({tag, "_busy"},  64'(busy),          64'd0);
        chk({tag, "_sb"},    64'(sb.size()),     64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) tick();
        chk("rst_wr_en",  64'(bus.wr_en),     64'd0);
        chk("rst_ready",  64'(bus.s_ready),   64'd0);
        chk("rst_busy",   64'(busy),          64'd0);
        chk("rst_calc",   64'(calc_init),     64'd0);
        chk("rst_words",  64'(words_written), 64'd0);
        chk("rst_addr",   64'(bus.wr_addr),   64'd0);
        rst_n = 1'b1;
        tick();

        // Nominal
        mark();
        do_start(32'h1000, 2);
        chk("nom_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) send(64'hA000 + 64'(i), i == 7, 0);
        finish_load("nom", 8, 0, 8);

        // Backpressure with random valid gaps
        mark();
        do_start(32'h1000, 2);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) stall(3);
            send(64'hB000 + 64'(i), i == 7, int'($urandom_range(0, 2)));
        end
        finish_load("bp", 8, 0, 8);

        // Zero size
        mark();
        do_start(32'h8000, 0);
        chk("zero_calc_n1", 64'(calc_init), 64'd0);
        chk("zero_busy_n1", 64'(busy),      64'd1);
        tick();
        chk("zero_calc_n2", 64'(calc_init), 64'd1);
        tick();
        chk("zero_calc_n3", 64'(calc_init), 64'd0);
        chk("zero_busy_n3", 64'(busy),      64'd0);
        repeat (2) tick();
        chk("zero_writes", 64'(wr_cnt - w0),   64'd0);
        chk("zero_calc",   64'(calc_cnt - c0), 64'd1);

        // Early s_last
        mark();
        do_start(32'h4000, 2);
        for (int i = 0; i < 5; i++) send(64'hC000 + 64'(i), i == 4, 0);
        finish_load("early", 5, 1, 5);

        // Missing s_last with start re-asserted mid-load
        mark();
        do_start(32'h5000, 2);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                start       = 1'b1;
                base_addr   = 32'hDEAD_0000;
                matrix_size = 11'd7;
            end
            if (i == 6) start = 1'b0;
            send(64'hD000 + 64'(i), 1'b0, 0);
        end
        finish_load("nolast", 8, 1, 8);

        // Reset mid-load
        mark();
        do_start(32'h2000, 3);
        for (int i = 0; i < 3; i++) send(64'hE000 + 64'(i), 1'b0, 0);
        @(negedge clk);
        #1;
        bus.s_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mrst_wr_en", 64'(bus.wr_en),     64'd0);
        chk("mrst_ready", 64'(bus.s_ready),   64'd0);
        chk("mrst_busy",  64'(busy),          64'd0);
        chk("mrst_words", 64'(words_written), 64'd0);
        chk("mrst_data",  bus.wr_data,        64'd0);
        repeat (3) tick();
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("mrst_calc",   64'(calc_cnt - c0), 64'd0);
        chk("mrst_writes", 64'(wr_cnt - w0),   64'd3);
        mark();
        do_start(32'h3000, 1);
        for (int i = 0; i < 4; i++) send(64'hF000 + 64'(i), i == 3, 0);
        finish_load("reload", 4, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bram_matrix_loader
`default_nettype wire
